memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, 32, byte address width on all ports.
REQ-002 Parameter DATA_WIDTH, 32, word width on all data ports.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ins_req  input  1  instruction read request from fetch stage.
REQ-006 ins_addr  input  ADDR_WIDTH  instruction read address.
REQ-007 ins_rdata  output  DATA_WIDTH  instruction word; valid when ins_req=1 and ins_busy=0.
REQ-008 ins_busy  output  1  instruction port stall to fetch stage.
REQ-009 data_req  input  1  data access request from memory stage.
REQ-010 data_we  input  1  1=write, 0=read.
REQ-011 data_addr  input  ADDR_WIDTH  data address.
REQ-012 data_wdata  input  DATA_WIDTH  store data.
REQ-013 data_be  input  DATA_WIDTH/8  store byte enables.
REQ-014 data_rdata  output  DATA_WIDTH  load data; valid when data_req=1 and data_busy=0.
REQ-015 data_busy  output  1  data port stall to memory stage.
REQ-016 mem_req, mem_we, mem_addr, mem_wdata, mem_be  outputs  1/1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  single shared memory port, all registered.
REQ-017 mem_rdata  input  DATA_WIDTH  memory read data, valid in the mem_ack cycle.
REQ-018 mem_ack  input  1  one-cycle completion pulse from memory.

Function
REQ-019 FSM states: IDLE, ACCESS, RESP; register grant selects INS or DATA.
REQ-020 IDLE: if any request is pending, the arbiter SHALL latch the winner's address, we, wdata, be into mem_* registers, set mem_req=1, and enter ACCESS on the next edge.
REQ-021 A read on the instruction port SHALL drive mem_we=0 and mem_be all ones.
REQ-022 ACCESS: mem_req and mem_* SHALL be held stable until mem_ack=1; on mem_ack, mem_rdata is registered, mem_req drops, and the FSM enters RESP.
REQ-023 RESP: the granted port's busy SHALL be 0 for exactly this one cycle with its rdata valid; the FSM returns to IDLE.
REQ-024 busy for a port = its req AND NOT (state=RESP AND grant=that port), combinational; a port with req=0 SHALL show busy=0.
REQ-025 Minimum latency, req to busy low: 3 cycles when mem_ack arrives the first cycle mem_req is high.
REQ-026 ins_rdata/data_rdata SHALL both reflect the captured register; only busy qualifies validity.
REQ-027 Default arbitration is fixed priority: when both requests are seen in IDLE, data wins.
REQ-028 A request withdrawn during ACCESS SHALL NOT abort the memory transaction; the result is discarded in RESP.
REQ-029 mem_ack in IDLE or RESP SHALL be ignored.
REQ-030 No state may be skipped: back-to-back requests incur one IDLE cycle between transactions.

Reset
REQ-031 On reset: state=IDLE, grant=INS, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, rdata register=0, last-served flag=INS.
REQ-032 Reset asserted during ACCESS SHALL drop mem_req on the next edge; the in-flight transaction is abandoned and a later mem_ack is ignored.
REQ-033 While reset=1, both busy outputs SHALL equal their req inputs.

Configuration
REQ-034 Macro MEMORY_ARBITER_ROUND_ROBIN_EN: when defined, simultaneous requests in IDLE SHALL be granted to the port not served last; when undefined, REQ-027 fixed data priority applies and no last-served flag is built.
REQ-035 With the macro defined, neither port SHALL wait for more than one other transaction under continuous contention.

Verification
REQ-036 ins_req only, addr 0x00400000, mem_ack on first ACCESS cycle with rdata 0x24080005 -> ins_busy low on cycle 3, ins_rdata=0x24080005, mem_we=0, mem_be=0xF.
REQ-037 data store, addr 0x10010004, wdata 0xDEADBEEF, be 0x3, ack after 4 wait cycles -> mem_* stable for 5 cycles, data_busy low exactly one cycle.
REQ-038 ins_req and data_req raised together, macro undefined -> data granted first, then instruction; ins_busy high throughout the data transaction.
REQ-039 Same contention held for 4 transactions, macro defined -> grants alternate DATA, INS, DATA, INS.
REQ-040 reset pulsed during ACCESS, then mem_ack pulse -> mem_req=0 next cycle, state IDLE, stray ack ignored, both rdata=0.
REQ-041 data_req withdrawn mid-ACCESS -> mem_req held until ack, no busy-low pulse on data port, ins request then served normally.

Source files
------------

// File: rtl/memory_arbiter.sv
// Two-port (instruction/data) arbiter onto a single registered memory port.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for alternating grants under contention.
module memory_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ins_req,
    input  logic [ADDR_WIDTH-1:0]   ins_addr,
    output logic [DATA_WIDTH-1:0]   ins_rdata,
    output logic                    ins_busy,
    input  logic                    data_req,
    input  logic                    data_we,
    input  logic [ADDR_WIDTH-1:0]   data_addr,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    input  logic [DATA_WIDTH/8-1:0] data_be,
    output logic [DATA_WIDTH-1:0]   data_rdata,
    output logic                    data_busy,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ack
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {GRANT_INS, GRANT_DATA} grant_t;

    state_t                  state_q;
    grant_t                  grant_q;
    grant_t                  grant_d;
    logic                    memReq_q;
    logic                    memWe_q;
    logic [ADDR_WIDTH-1:0]   memAddr_q;
    logic [DATA_WIDTH-1:0]   memWdata_q;
    logic [BE_WIDTH-1:0]     memBe_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    grant_t                  lastServed_q;

    always_comb begin
        grant_d = GRANT_INS;
        if (ins_req && data_req) begin
            grant_d = (lastServed_q == GRANT_DATA) ? GRANT_INS : GRANT_DATA;
        end else if (data_req) begin
            grant_d = GRANT_DATA;
        end
    end
`else
    always_comb begin
        grant_d = data_req ? GRANT_DATA : GRANT_INS;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= GRANT_INS;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            memBe_q    <= '0;
            rdata_q    <= '0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            lastServed_q <= GRANT_INS;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (ins_req || data_req) begin
                        grant_q  <= grant_d;
                        memReq_q <= 1'b1;
                        state_q  <= ACCESS;
                        if (grant_d == GRANT_DATA) begin
                            memWe_q    <= data_we;
                            memAddr_q  <= data_addr;
                            memWdata_q <= data_wdata;
                            memBe_q    <= data_be;
                        end else begin
                            memWe_q    <= 1'b0;
                            memAddr_q  <= ins_addr;
                            memWdata_q <= '0;
                            memBe_q    <= '1;
                        end
                    end
                end
                // Withdrawn requests still complete here; RESP simply shows no busy pulse.
                ACCESS: begin
                    if (mem_ack) begin
                        rdata_q  <= mem_rdata;
                        memReq_q <= 1'b0;
                        state_q  <= RESP;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
                        lastServed_q <= grant_q;
`endif
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req    = memReq_q;
    assign mem_we     = memWe_q;
    assign mem_addr   = memAddr_q;
    assign mem_wdata  = memWdata_q;
    assign mem_be     = memBe_q;
    assign ins_rdata  = rdata_q;
    assign data_rdata = rdata_q;

    // Reset masks the response cycle so busy mirrors req while reset is held.
    assign ins_busy  = ins_req  && !(!reset && state_q == RESP && grant_q == GRANT_INS);
    assign data_busy = data_req && !(!reset && state_q == RESP && grant_q == GRANT_DATA);

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: transaction-level reference model with
// randomized requests, wait states, withdrawals and stray acks.
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ins_req;
    logic [31:0] ins_addr;
    logic [31:0] ins_rdata;
    logic        ins_busy;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_be;
    logic [31:0] data_rdata;
    logic        data_busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    // Requester-side view: what each port currently wants served.
    bit          insPend;
    logic [31:0] insAddr;
    bit          dataPend;
    bit          dataWe;
    logic [31:0] dataAddr;
    logic [31:0] dataWdata;
    logic [3:0]  dataBe;
    bit          lastServedData;

    memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .ins_req(ins_req), .ins_addr(ins_addr), .ins_rdata(ins_rdata), .ins_busy(ins_busy),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_be(data_be), .data_rdata(data_rdata),
        .data_busy(data_busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        ins_req    = insPend;
        ins_addr   = insAddr;
        data_req   = dataPend;
        data_we    = dataWe;
        data_addr  = dataAddr;
        data_wdata = dataWdata;
        data_be    = dataBe;
    endtask

    task automatic newIns(input logic [31:0] addr);
        insPend = 1'b1;
        insAddr = addr;
    endtask

    task automatic newData(input bit we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        dataPend  = 1'b1;
        dataWe    = we;
        dataAddr  = addr;
        dataWdata = wd;
        dataBe    = be;
    endtask

    // Called in an IDLE cycle with at least one request pending; returns in the next IDLE cycle.
    task automatic runTransaction(input int waits, input bit withdraw, input logic [31:0] rdVal);
        bit          winData;
        logic [31:0] expAddr;
        bit          expWe;
        logic [31:0] expWdata;
        logic [3:0]  expBe;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        winData = (insPend && dataPend) ? !lastServedData : dataPend;
`else
        winData = dataPend;
`endif
        if (winData) begin
            expAddr = dataAddr; expWe = dataWe; expWdata = dataWdata; expBe = dataBe;
        end else begin
            expAddr = insAddr; expWe = 1'b0; expWdata = '0; expBe = 4'hF;
        end
        applyStimulus();
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        checkOutput("idle_mem_req", 64'(mem_req), 64'(0));
        checkOutput("idle_ins_busy", 64'(ins_busy), 64'(insPend));
        checkOutput("idle_data_busy", 64'(data_busy), 64'(dataPend));
        step();
        for (int i = 0; i <= waits; i++) begin
            if (withdraw && i == 0) begin
                if (winData) dataPend = 1'b0; else insPend = 1'b0;
                applyStimulus();
            end
            mem_ack   = (i == waits);
            mem_rdata = (i == waits) ? rdVal : $urandom;
            #1;
            checkOutput("acc_mem_req", 64'(mem_req), 64'(1));
            checkOutput("acc_mem_addr", 64'(mem_addr), 64'(expAddr));
            checkOutput("acc_mem_we", 64'(mem_we), 64'(expWe));
            checkOutput("acc_mem_be", 64'(mem_be), 64'(expBe));
            if (winData) checkOutput("acc_mem_wdata", 64'(mem_wdata), 64'(expWdata));
            checkOutput("acc_ins_busy", 64'(ins_busy), 64'(insPend));
            checkOutput("acc_data_busy", 64'(data_busy), 64'(dataPend));
            step();
        end
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        checkOutput("resp_mem_req", 64'(mem_req), 64'(0));
        checkOutput("resp_ins_rdata", 64'(ins_rdata), 64'(rdVal));
        checkOutput("resp_data_rdata", 64'(data_rdata), 64'(rdVal));
        checkOutput("resp_ins_busy", 64'(ins_busy), 64'(winData ? insPend : 1'b0));
        checkOutput("resp_data_busy", 64'(data_busy), 64'(winData ? 1'b0 : dataPend));
        lastServedData = winData;
        if (winData) dataPend = 1'b0; else insPend = 1'b0;
        step();
        mem_ack = 1'b0;
        applyStimulus();
    endtask

    initial begin
        reset = 1'b1;
        insPend = 0; insAddr = '0;
        dataPend = 0; dataWe = 0; dataAddr = '0; dataWdata = '0; dataBe = '0;
        lastServedData = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        applyStimulus();
        step();
        step();
        ins_req = 1'b1; data_req = 1'b1;
        #1;
        checkOutput("rst_ins_busy", 64'(ins_busy), 64'(1));
        checkOutput("rst_data_busy", 64'(data_busy), 64'(1));
        checkOutput("rst_mem_req", 64'(mem_req), 64'(0));
        checkOutput("rst_mem_addr", 64'(mem_addr), 64'(0));
        checkOutput("rst_mem_be", 64'(mem_be), 64'(0));
        checkOutput("rst_rdata", 64'(ins_rdata), 64'(0));
        applyStimulus();
        reset = 1'b0;
        step();

        newIns(32'h0040_0000);
        runTransaction(0, 1'b0, 32'h2408_0005);
        newData(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'h3);
        runTransaction(4, 1'b0, $urandom);

        newIns(32'h0040_0004);
        newData(1'b0, 32'h1001_0008, 32'h0, 4'hF);
        runTransaction(1, 1'b0, $urandom);
        runTransaction(0, 1'b0, $urandom);

        for (int t = 0; t < 4; t++) begin
            if (!insPend) newIns($urandom & 32'hFFFF_FFFC);
            if (!dataPend) newData(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom));
            runTransaction(t % 2, 1'b0, $urandom);
        end
        if (insPend) runTransaction(0, 1'b0, $urandom);
        if (dataPend) runTransaction(0, 1'b0, $urandom);

        newData(1'b0, 32'h1001_0010, 32'h0, 4'hF);
        runTransaction(2, 1'b1, $urandom);
        newIns(32'h0040_0008);
        runTransaction(0, 1'b0, 32'h1234_5678);

        newData(1'b1, 32'h1001_0020, 32'hCAFE_F00D, 4'hF);
        applyStimulus();
        step();
        checkOutput("ra_mem_req_acc", 64'(mem_req), 64'(1));
        reset = 1'b1;
        #1;
        checkOutput("ra_data_busy_rst", 64'(data_busy), 64'(1));
        step();
        checkOutput("ra_mem_req_drop", 64'(mem_req), 64'(0));
        reset = 1'b0;
        dataPend = 1'b0; insPend = 1'b0;
        lastServedData = 1'b0;
        applyStimulus();
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ack = 1'b0;
        #1;
        checkOutput("ra_stray_mem_req", 64'(mem_req), 64'(0));
        checkOutput("ra_ins_rdata", 64'(ins_rdata), 64'(0));
        checkOutput("ra_data_rdata", 64'(data_rdata), 64'(0));
        checkOutput("ra_busy", 64'({ins_busy, data_busy}), 64'(0));
        step();

        for (int ep = 0; ep < 200; ep++) begin
            if (!insPend && $urandom_range(0, 1) == 1) newIns($urandom & 32'hFFFF_FFFC);
            if (!dataPend && $urandom_range(0, 1) == 1)
                newData(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom));
            if (!insPend && !dataPend) newIns($urandom & 32'hFFFF_FFFC);
            runTransaction($urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
